// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage and its entry buffer.
package alu_pkg;

  // Operand/result width shared with the upstream add/sub + shift block.
  localparam int ALU_N = 4;

  // Opcodes: sel picks d[sel]; 0-3 are the add/sub result, 4-7 are shifts.
  localparam logic [2:0] OP_ADD0  = 3'd0;
  localparam logic [2:0] OP_ADD1  = 3'd1;
  localparam logic [2:0] OP_ADD2  = 3'd2;
  localparam logic [2:0] OP_ADD3  = 3'd3;
  localparam logic [2:0] OP_SHL_A = 3'd4;
  localparam logic [2:0] OP_SHL_B = 3'd5;
  localparam logic [2:0] OP_SAR_A = 3'd6;
  localparam logic [2:0] OP_SAR_B = 3'd7;

  // One buffered operation: result plus the flags captured at push time.
  typedef struct packed {
    logic [ALU_N-1:0] result;
    logic             n;
    logic             z;
    logic             c;
  } alu_entry_t;

  // Add/sub opcodes have the top opcode bit clear.
  function automatic logic is_arith_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Build an entry from the selected result. For add/sub, N comes from the
  // upstream MSB (identical to result[MSB]) and C from the upstream carry;
  // shifts never report a carry.
  function automatic alu_entry_t make_entry(input logic [ALU_N-1:0] res,
                                            input logic             arith,
                                            input logic             msb_in,
                                            input logic             carry_in);
    alu_entry_t e;
    e.result = res;
    e.n      = arith ? msb_in : res[ALU_N-1];
    e.z      = (res == '0);
    e.c      = arith & carry_in;
    return e;
  endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// result_fifo2: 2-entry valid/ready FIFO of alu_entry_t.
// Slot 0 is always the head, so the output holds its last value when empty.
module result_fifo2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  alu_entry_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output alu_entry_t out_data
);

  logic [1:0] count_q, count_d;
  alu_entry_t slot0_q, slot0_d;
  alu_entry_t slot1_q, slot1_d;
  logic       push;
  logic       pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state for occupancy and slots; a pop shifts slot 1 into the head.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = in_data;
        else                 slot1_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at count 1 (count 2 blocks push, count 0 blocks pop).
        if (count_q == 2'd1) begin
          slot0_d = in_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and slot registers; reset discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: opcode mux, N/Z/C flag generation, 2-entry output
// buffer, sticky carry and wrapping completed-operation counter.
// N must equal alu_pkg::ALU_N, since the buffered entry type is sized by it.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = ALU_N,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     d0,
  input  logic [N-1:0]     d1,
  input  logic [N-1:0]     d2,
  input  logic [N-1:0]     d3,
  input  logic [N-1:0]     d4,
  input  logic [N-1:0]     d5,
  input  logic [N-1:0]     d6,
  input  logic [N-1:0]     d7,
  input  logic             carry_out,
  input  logic             msb_result,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             sticky_c,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  logic [N-1:0]     selected;
  alu_entry_t       push_entry;
  alu_entry_t       head_entry;
  logic             pop;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Opcode mux over the eight candidate results.
  always_comb begin
    selected = d0;
    case (sel)
      OP_ADD0:  selected = d0;
      OP_ADD1:  selected = d1;
      OP_ADD2:  selected = d2;
      OP_ADD3:  selected = d3;
      OP_SHL_A: selected = d4;
      OP_SHL_B: selected = d5;
      OP_SAR_A: selected = d6;
      OP_SAR_B: selected = d7;
      default:  selected = d0;
    endcase
  end

  assign push_entry = make_entry(selected, is_arith_op(sel), msb_result, carry_out);

  result_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry)
  );

  assign pop = out_valid & out_ready;

  // Sticky carry and completion counter; a set-by-pop overrides a clear.
  always_comb begin
    sticky_d   = sticky_q;
    op_count_d = op_count_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (pop) begin
      if (head_entry.c) sticky_d = 1'b1;
      op_count_d = op_count_q + 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  assign result   = head_entry.result;
  assign flag_n   = head_entry.n;
  assign flag_z   = head_entry.z;
  assign flag_c   = head_entry.c;
  assign sticky_c = sticky_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage (N=4, CNT_W=8).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic [3:0] d [8];
  logic       carry_out;
  logic       msb_result;
  logic [2:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       sticky_c;
  logic       clr_sticky;
  logic [7:0] op_count;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  alu_result_stage #(.N(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d0         (d[0]),
    .d1         (d[1]),
    .d2         (d[2]),
    .d3         (d[3]),
    .d4         (d[4]),
    .d5         (d[5]),
    .d6         (d[6]),
    .d7         (d[7]),
    .carry_out  (carry_out),
    .msb_result (msb_result),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .sticky_c   (sticky_c),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++;
    if ({result, flag_n, flag_z, flag_c} !== 7'h00)
      $display("FAIL rst_result_flags got=%h/%b%b%b exp=0/000", result, flag_n, flag_z, flag_c);
    else n_pass++;
    n_total++;
    if ({sticky_c, op_count} !== 9'h000)
      $display("FAIL rst_sticky_cnt got=%b/%0d exp=0/0", sticky_c, op_count);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL post_rst_ready got=%b%b exp=10", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_add();
    d[0] = 4'b0000; sel = 3'd0; carry_out = 1'b1; msb_result = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, result, flag_n, flag_z, flag_c} !== {1'b1, 4'h0, 3'b011})
      $display("FAIL add_entry got=v%b r=%h nzc=%b%b%b exp=v1 r=0 nzc=011",
               out_valid, result, flag_n, flag_z, flag_c);
    else n_pass++;
    n_total++;
    if (sticky_c !== 1'b0) $display("FAIL add_sticky_early got=%b exp=0", sticky_c); else n_pass++;
    step();
    exp_cnt = 1;
    n_total++;
    if ({sticky_c, out_valid, op_count} !== {1'b1, 1'b0, 8'd1})
      $display("FAIL add_pop got=s%b v%b cnt=%0d exp=s1 v0 cnt=1", sticky_c, out_valid, op_count);
    else n_pass++;
  endtask

  task automatic test_shift();
    d[6] = 4'b1100; sel = 3'd6; carry_out = 1'b1; msb_result = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({result, flag_n, flag_z, flag_c} !== {4'b1100, 3'b100})
      $display("FAIL shift_entry got=r=%b nzc=%b%b%b exp=r=1100 nzc=100",
               result, flag_n, flag_z, flag_c);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid, result} !== {1'b1, 4'b1100})
      $display("FAIL shift_hold got=v%b r=%b exp=v1 r=1100", out_valid, result);
    else n_pass++;
    out_ready = 1'b1;
    step();
    exp_cnt++;
    out_ready = 1'b0;
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'(exp_cnt)})
      $display("FAIL shift_pop got=v%b cnt=%0d exp=v0 cnt=%0d", out_valid, op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_select();
    logic [3:0] vals [8];
    logic [6:0] exp [8];
    vals = '{4'h9, 4'h1, 4'h0, 4'h7, 4'h6, 4'hE, 4'h0, 4'h3};
    exp  = '{{4'h9, 3'b100}, {4'h1, 3'b001}, {4'h0, 3'b010}, {4'h7, 3'b001},
             {4'h6, 3'b000}, {4'hE, 3'b100}, {4'h0, 3'b010}, {4'h3, 3'b000}};
    for (int i = 0; i < 8; i++) d[i] = vals[i];
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      carry_out = k[0];
      msb_result = (k < 4) ? vals[k][3] : ~vals[k][3];
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      n_total++;
      if ({result, flag_n, flag_z, flag_c} !== exp[k])
        $display("FAIL select_%0d got=r=%h nzc=%b%b%b exp=%h", k, result, flag_n, flag_z,
                 flag_c, exp[k]);
      else n_pass++;
      out_ready = 1'b1;
      step();
      exp_cnt++;
    end
    out_ready = 1'b0;
    n_total++;
    if ({sticky_c, op_count} !== {1'b1, 8'(exp_cnt)})
      $display("FAIL select_status got=s%b cnt=%0d exp=s1 cnt=%0d", sticky_c, op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    sel = 3'd0; carry_out = 1'b0; msb_result = 1'b0; out_ready = 1'b0;
    d[0] = 4'd1; in_valid = 1'b1;
    step();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_1 got=%b exp=1", in_ready); else n_pass++;
    d[0] = 4'd2;
    step();
    d[0] = 4'd3;
    n_total++;
    if ({in_ready, out_valid, result} !== {2'b01, 4'd1})
      $display("FAIL bp_full got=rdy%b v%b r=%0d exp=rdy0 v1 r=1", in_ready, out_valid, result);
    else n_pass++;
    step();
    n_total++;
    if ({in_ready, result} !== {1'b0, 4'd1})
      $display("FAIL bp_held got=rdy%b r=%0d exp=rdy0 r=1", in_ready, result);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_total++;
    if ({in_ready, result} !== {1'b1, 4'd2})
      $display("FAIL bp_out2 got=rdy%b r=%0d exp=rdy1 r=2", in_ready, result);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, result} !== {1'b1, 4'd3})
      $display("FAIL bp_out3 got=v%b r=%0d exp=v1 r=3", out_valid, result);
    else n_pass++;
    step();
    exp_cnt += 3;
    out_ready = 1'b0;
    n_total++;
    if ({out_valid, result, op_count} !== {1'b0, 4'd3, 8'(exp_cnt)})
      $display("FAIL bp_drain got=v%b r=%0d cnt=%0d exp=v0 r=3 cnt=%0d", out_valid, result,
               op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int errs;
    sel = 3'd0; carry_out = 1'b0; msb_result = 1'b0;
    d[0] = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    out_ready = 1'b1;
    errs = 0;
    for (int i = 1; i <= 10; i++) begin
      d[0] = 4'(i);
      step();
      if ({out_valid, in_ready, result} !== {2'b11, 4'(i)}) begin
        $display("FAIL b2b_step_%0d got=v%b rdy%b r=%0d exp=v1 rdy1 r=%0d", i, out_valid,
                 in_ready, result, i);
        errs++;
      end
    end
    n_total++;
    if (errs != 0) $display("FAIL b2b_stream got=%0d bad steps exp=0", errs); else n_pass++;
    exp_cnt += 10;
    n_total++;
    if (op_count !== 8'(exp_cnt))
      $display("FAIL b2b_count got=%0d exp=%0d", op_count, exp_cnt);
    else n_pass++;
    in_valid = 1'b0;
    step();
    exp_cnt++;
    out_ready = 1'b0;
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'(exp_cnt)})
      $display("FAIL b2b_drain got=v%b cnt=%0d exp=v0 cnt=%0d", out_valid, op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_sticky();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    n_total++;
    if (sticky_c !== 1'b0) $display("FAIL sticky_clear got=%b exp=0", sticky_c); else n_pass++;
    d[4] = 4'h2; sel = 3'd4; carry_out = 1'b1; msb_result = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    exp_cnt++;
    n_total++;
    if (sticky_c !== 1'b0) $display("FAIL sticky_shift_pop got=%b exp=0", sticky_c); else n_pass++;
    d[1] = 4'h5; sel = 3'd1; carry_out = 1'b1; msb_result = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
    step();
    exp_cnt++;
    out_ready = 1'b0;
    n_total++;
    if (sticky_c !== 1'b1) $display("FAIL sticky_set_wins got=%b exp=1", sticky_c); else n_pass++;
    step();
    clr_sticky = 1'b0;
    n_total++;
    if (sticky_c !== 1'b0) $display("FAIL sticky_clr_alone got=%b exp=0", sticky_c); else n_pass++;
  endtask

  task automatic test_wrap();
    int need;
    need = 255 - (exp_cnt % 256);
    sel = 3'd4; d[4] = 4'h8; carry_out = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    for (int i = 0; i < need; i++) step();
    n_total++;
    if (op_count !== 8'd255) $display("FAIL wrap_pre got=%0d exp=255", op_count); else n_pass++;
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    exp_cnt = 0;
    n_total++;
    if ({op_count, out_valid} !== {8'd0, 1'b0})
      $display("FAIL wrap_zero got=cnt=%0d v%b exp=cnt=0 v0", op_count, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    sel = 3'd7; d[7] = 4'h6; carry_out = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    d[7] = 4'hA; in_valid = 1'b1;
    step();
    d[7] = 4'hB;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({in_ready, out_valid, op_count} !== {2'b01, 8'd1})
      $display("FAIL mid_pre got=rdy%b v%b cnt=%0d exp=rdy0 v1 cnt=1", in_ready, out_valid,
               op_count);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, in_ready, op_count, result} !== {2'b01, 8'd0, 4'h0})
      $display("FAIL mid_reset got=v%b rdy%b cnt=%0d r=%h exp=v0 rdy1 cnt=0 r=0", out_valid,
               in_ready, op_count, result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    d[7] = 4'h3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, result} !== {1'b1, 4'h3})
      $display("FAIL mid_after got=v%b r=%h exp=v1 r=3", out_valid, result);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = 4'hA;
    carry_out = 1'b0; msb_result = 1'b0; sel = 3'd0;
    in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    test_reset();
    test_add();
    test_shift();
    test_select();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
